// File: rtl/regfile_wb_pipe_if.sv
// Write-back request bus into the register file and the in-flight commit it reports back.
interface regfile_wb_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_valid;
   logic [1:0]        wb_src;
   logic [ADDR_W-1:0] wb_dst;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] link_addr;
   logic              commit_valid;
   logic [ADDR_W-1:0] commit_addr;
   logic [DATA_W-1:0] commit_data;

   modport master (
      output wb_valid, wb_src, wb_dst, alu_result, mem_data, link_addr,
      input  commit_valid, commit_addr, commit_data
   );

   modport slave (
      input  wb_valid, wb_src, wb_dst, alu_result, mem_data, link_addr,
      output commit_valid, commit_addr, commit_data
   );
endinterface

// File: rtl/regfile_wb_pipe.sv
// Decode-stage register file: one registered write-back stage with read bypass,
// NUM_RD combinational read ports and a per-register load scoreboard.
module regfile_wb_pipe #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int LINK_REG = 2**ADDR_W - 1
) (
   input  logic                     clock,
   input  logic                     reset,
   regfile_wb_pipe_if.slave         wb,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_stall,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   input  logic                     sb_clr,
   input  logic [ADDR_W-1:0]        sb_clr_addr,
   output logic [2**ADDR_W-1:0]     busy_mask
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_A = LINK_REG[ADDR_W-1:0];

   logic [DATA_W-1:0] regs [DEPTH];

   logic              wb_q_valid;
   logic [ADDR_W-1:0] wb_q_addr;
   logic [DATA_W-1:0] wb_q_data;

   logic [ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0] wb_src_data;
   logic              wb_accept;
   logic [DEPTH-1:0]  busy_next;

   assign wb_dest   = (wb.wb_src == 2'd2) ? LINK_A : wb.wb_dst;
   assign wb_accept = wb.wb_valid && (wb.wb_src != 2'd3) && (wb_dest != '0);

   always_comb begin
      case (wb.wb_src)
         2'd0:    wb_src_data = wb.alu_result;
         2'd1:    wb_src_data = wb.mem_data;
         2'd2:    wb_src_data = wb.link_addr;
         default: wb_src_data = '0;
      endcase
   end

   // Write-back stage and array commit share the edge, so a new request can
   // load WB_Q while the previous one retires into the array.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_q_valid <= 1'b0;
         wb_q_addr  <= '0;
         wb_q_data  <= '0;
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
      end else begin
         wb_q_valid <= wb_accept;
         wb_q_addr  <= wb_dest;
         wb_q_data  <= wb_src_data;
         if (wb_q_valid && (wb_q_addr != '0)) begin
            regs[wb_q_addr] <= wb_q_data;
         end
      end
   end

   // Clear first, then set: a new load issued in the same cycle supersedes the returning one.
   always_comb begin
      busy_next = busy_mask;
      if (sb_clr) begin
         busy_next[sb_clr_addr] = 1'b0;
      end
      if (sb_set) begin
         busy_next[sb_set_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
      end
   end

   assign wb.commit_valid = wb_q_valid;
   assign wb.commit_addr  = wb_q_addr;
   assign wb.commit_data  = wb_q_data;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_data[i*DATA_W +: DATA_W] =
         (addr == '0)                          ? '0        :
         (wb_q_valid && (wb_q_addr == addr))   ? wb_q_data :
                                                 regs[addr];
      assign rd_stall[i] = busy_mask[addr];
   end
endmodule

// File: tb/tb_regfile_wb_pipe.sv
// Bench for regfile_wb_pipe: directed steps then random traffic against an
// architectural model where a write is visible from the cycle after it is issued.
module tb_regfile_wb_pipe;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_stall;
   logic        sb_set, sb_clr;
   logic [4:0]  sb_set_addr, sb_clr_addr;
   logic [31:0] busy_mask;

   regfile_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) wb_if ();

   regfile_wb_pipe dut (
      .clock       (clock),
      .reset       (reset),
      .wb          (wb_if.slave),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_stall    (rd_stall),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .sb_clr      (sb_clr),
      .sb_clr_addr (sb_clr_addr),
      .busy_mask   (busy_mask)
   );

   logic        wbv;
   logic [1:0]  wbs;
   logic [4:0]  wbd;
   logic [31:0] alu, mem, lnk;
   logic [4:0]  ra0, ra1;

   assign wb_if.wb_valid   = wbv;
   assign wb_if.wb_src     = wbs;
   assign wb_if.wb_dst     = wbd;
   assign wb_if.alu_result = alu;
   assign wb_if.mem_data   = mem;
   assign wb_if.link_addr  = lnk;
   assign rd_addr          = {ra1, ra0};

   // Architectural model
   logic [31:0] m_reg [32];
   logic [31:0] m_busy;
   logic        m_cv;
   logic [4:0]  m_ca;
   logic [31:0] m_cd;
   bit          m_after_reset;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [4:0]  a;
      logic [31:0] exp_d;
      for (int i = 0; i < 2; i++) begin
         a     = (i == 0) ? ra0 : ra1;
         exp_d = (a == 5'd0) ? 32'd0 : m_reg[a];
         chk($sformatf("%s rd_data[%0d] addr %0d", tag, i, a), {32'd0, rd_data[i*32 +: 32]}, {32'd0, exp_d});
         chk($sformatf("%s rd_stall[%0d] addr %0d", tag, i, a), {63'd0, rd_stall[i]}, {63'd0, m_busy[a]});
      end
      chk({tag, " busy_mask"}, {32'd0, busy_mask}, {32'd0, m_busy});
      chk({tag, " commit_valid"}, {63'd0, wb_if.commit_valid}, {63'd0, m_cv});
      if (m_cv || m_after_reset) begin
         chk({tag, " commit_addr"}, {59'd0, wb_if.commit_addr}, {59'd0, m_ca});
         chk({tag, " commit_data"}, {32'd0, wb_if.commit_data}, {32'd0, m_cd});
      end
   endtask

   task automatic model_edge();
      logic [4:0]  dest;
      logic [31:0] data;
      if (reset) begin
         for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
         m_busy        = 32'd0;
         m_cv          = 1'b0;
         m_ca          = 5'd0;
         m_cd          = 32'd0;
         m_after_reset = 1'b1;
      end else begin
         m_after_reset = 1'b0;
         dest = (wbs == 2'd2) ? 5'd31 : wbd;
         data = (wbs == 2'd0) ? alu : (wbs == 2'd1) ? mem : lnk;
         m_cv = wbv && (wbs != 2'd3) && (dest != 5'd0);
         if (m_cv) begin
            m_reg[dest] = data;
            m_ca        = dest;
            m_cd        = data;
         end
         if (sb_clr) m_busy[sb_clr_addr] = 1'b0;
         if (sb_set) m_busy[sb_set_addr] = 1'b1;
         m_busy[0] = 1'b0;
      end
   endtask

   // Inputs are set by the caller just after the previous edge; outputs are checked at negedge.
   task automatic step(input string tag, input bit do_chk);
      @(negedge clock);
      #1;
      if (do_chk) check_all(tag);
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wbv = 1'b0; wbs = 2'd0; wbd = 5'd0;
      alu = 32'd0; mem = 32'd0; lnk = 32'd0;
      sb_set = 1'b0; sb_set_addr = 5'd0; sb_clr = 1'b0; sb_clr_addr = 5'd0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      ra0 = 5'd0; ra1 = 5'd0;
      m_busy = 32'd0; m_cv = 1'b0; m_ca = 5'd0; m_cd = 32'd0; m_after_reset = 1'b0;
      for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;

      step("reset0", 1'b0);
      step("reset1", 1'b1);
      reset = 1'b0;

      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'((i + 16) % 32);
         step("sweep", 1'b1);
      end

      // ALU write to r5 with bypass and array read-back
      wbv = 1'b1; wbs = 2'd0; wbd = 5'd5; alu = 32'hDEADBEEF; ra0 = 5'd5; ra1 = 5'd5;
      step("alu_n", 1'b1);
      idle_inputs();
      step("alu_n1_bypass", 1'b1);
      step("alu_n2", 1'b1);
      step("alu_n3_array", 1'b1);

      // Link write lands in r31 regardless of wb_dst
      wbv = 1'b1; wbs = 2'd2; wbd = 5'd7; lnk = 32'h0040_0010; ra0 = 5'd31; ra1 = 5'd7;
      step("link_n", 1'b1);
      idle_inputs();
      step("link_n1", 1'b1);
      step("link_n2", 1'b1);

      // Write to r0 is dropped
      wbv = 1'b1; wbs = 2'd1; wbd = 5'd0; mem = 32'h1234; ra0 = 5'd0; ra1 = 5'd0;
      step("r0_n", 1'b1);
      idle_inputs();
      step("r0_n1", 1'b1);

      // Back-to-back writes to r9
      ra0 = 5'd9; ra1 = 5'd9;
      wbv = 1'b1; wbs = 2'd0; wbd = 5'd9; alu = 32'h11;
      step("b2b_a", 1'b1);
      alu = 32'h22;
      step("b2b_b", 1'b1);
      idle_inputs();
      step("b2b_c", 1'b1);
      step("b2b_d", 1'b1);
      step("b2b_e", 1'b1);

      // Reserved source writes nothing
      wbv = 1'b1; wbs = 2'd3; wbd = 5'd9; alu = 32'h99; mem = 32'h99; lnk = 32'h99;
      step("rsv_n", 1'b1);
      idle_inputs();
      step("rsv_n1", 1'b1);

      // Scoreboard set / set+clr / clr / r0
      ra0 = 5'd12; ra1 = 5'd13;
      sb_set = 1'b1; sb_set_addr = 5'd12;
      step("sb_set", 1'b1);
      idle_inputs();
      step("sb_busy", 1'b1);
      sb_set = 1'b1; sb_set_addr = 5'd12; sb_clr = 1'b1; sb_clr_addr = 5'd12;
      step("sb_setclr", 1'b1);
      idle_inputs();
      step("sb_still_busy", 1'b1);
      sb_clr = 1'b1; sb_clr_addr = 5'd12;
      step("sb_clr", 1'b1);
      idle_inputs();
      step("sb_cleared", 1'b1);
      ra0 = 5'd0;
      sb_set = 1'b1; sb_set_addr = 5'd0;
      step("sb_r0", 1'b1);
      idle_inputs();
      step("sb_r0_idle", 1'b1);

      // Reset drops an in-flight write and busy bits
      sb_set = 1'b1; sb_set_addr = 5'd4;
      step("rst_pre_a", 1'b1);
      sb_set_addr = 5'd6;
      wbv = 1'b1; wbs = 2'd0; wbd = 5'd3; alu = 32'hCAFE_F00D; ra0 = 5'd3; ra1 = 5'd4;
      step("rst_pre_b", 1'b1);
      idle_inputs();
      reset = 1'b1;
      wbv = 1'b1; wbd = 5'd3; alu = 32'h5555_AAAA; sb_set = 1'b1; sb_set_addr = 5'd8;
      step("rst_edge", 1'b1);
      reset = 1'b0;
      idle_inputs();
      step("rst_after", 1'b1);
      step("rst_after2", 1'b1);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         reset       = ($urandom_range(0, 79) == 0);
         wbv         = ($urandom_range(0, 3) != 0);
         wbs         = 2'($urandom_range(0, 3));
         wbd         = 5'($urandom_range(0, 15));
         alu         = $urandom;
         mem         = $urandom;
         lnk         = $urandom;
         sb_set      = ($urandom_range(0, 2) == 0);
         sb_set_addr = 5'($urandom_range(0, 7));
         sb_clr      = ($urandom_range(0, 1) == 0);
         sb_clr_addr = 5'($urandom_range(0, 7));
         ra0         = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
         ra1         = 5'($urandom_range(0, 15));
         step("rand", 1'b1);
      end
      reset = 1'b0;
      idle_inputs();
      step("final", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_wb_pipe.md
# regfile_wb_pipe

Parametrised register file with a registered write-back stage, read bypass and a load scoreboard. It sits in the decode stage of the CPU. It takes the same write-back sources as the current decoder (ALU result, memory/IO data, link address) and generalises data width, register count and number of read ports. It adds a pipelined commit, forwarding of the in-flight write, and per-register pending tracking with stall outputs.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- NUM_RD, 2, number of independent read ports
- LINK_REG, 2^ADDR_W-1, destination forced for link write-back

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_stall  out  NUM_RD  port i reads a scoreboard-pending register
- wb_valid  in  1  write-back request this cycle
- wb_src  in  2  0 = ALU, 1 = mem/IO, 2 = link, 3 = reserved (no write)
- wb_dst  in  ADDR_W  destination; ignored when wb_src = 2
- alu_result, mem_data, link_addr  in  DATA_W each  write-back sources
- sb_set, sb_set_addr  in  1, ADDR_W  mark register pending (load issued)
- sb_clr, sb_clr_addr  in  1, ADDR_W  clear pending mark (load returned)
- busy_mask  out  2^ADDR_W  current scoreboard bits
- commit_valid, commit_addr, commit_data  out  1, ADDR_W, DATA_W  in-flight write-back stage contents

## Operation
- Stage WB_Q (posedge):
  - wb_q_valid <= wb_valid && wb_src != 3 && dest != 0.
  - dest = LINK_REG if wb_src = 2, else wb_dst.
  - wb_q_data = source selected by wb_src.
- Array write (posedge): if wb_q_valid, reg[wb_q_addr] <= wb_q_data. Register 0 is never written and always reads 0.
- commit_valid/addr/data drive wb_q_valid/addr/data directly.
- Read port i, priority order:
  - rd_addr_i = 0 -> 0
  - else wb_q_valid && wb_q_addr = rd_addr_i -> wb_q_data (bypass)
  - else reg[rd_addr_i]
- Scoreboard, per bit b at posedge:
  - set if sb_set && sb_set_addr = b
  - else clear if sb_clr && sb_clr_addr = b
  - Set and clear of the same address in one cycle: set wins, because a new load supersedes the old one.
  - Bit 0 is never set.
- rd_stall[i] = busy_mask[rd_addr_i], combinational. The scoreboard does not gate writes; the write-back stage writes regardless of busy state.
- Reset, applied at posedge while reset = 1:
  - all registers 0, wb_q_valid 0, wb_q_addr 0, wb_q_data 0, busy_mask 0.
  - A write in WB_Q when reset asserts is dropped.
  - Inputs are ignored while reset is high.

## Timing
- Reset values: rd_data all 0, rd_stall 0, busy_mask 0, commit_valid 0, commit_addr 0, commit_data 0.
- Write-back latency: wb_valid at cycle N makes the value readable via bypass in cycle N+1 and from the array from cycle N+2 on. There are no read-after-write gaps.
- Back-to-back writes to the same register at N and N+1: reads at N+2 return the N+1 value. The bypass always shows the younger write.
- A write in WB_Q and a new wb_valid in the same cycle are both legal. The array write and the WB_Q reload happen on the same edge.
- Scoreboard change at posedge N is visible on rd_stall/busy_mask after that edge (cycle N+1).
- rd_data and rd_stall are purely combinational from rd_addr and state; there are no combinational paths from wb_* inputs to rd_data.

## Test plan
- Reset then read all 32 addresses on both ports -> every rd_data = 0, busy_mask = 0, commit_valid = 0.
- wb_valid with wb_src=0, wb_dst=5, alu_result=0xDEADBEEF at cycle N:
  - rd_addr0=5 at N -> old value 0.
  - At N+1 -> 0xDEADBEEF via bypass, commit_addr=5.
  - At N+3 -> 0xDEADBEEF from the array.
- wb_src=2, wb_dst=7, link_addr=0x0040_0010 -> register 31 = 0x0040_0010, register 7 unchanged. wb_src=1, wb_dst=0, mem_data=0x1234 -> register 0 still 0, commit_valid stays 0.
- Consecutive writes to register 9 of 0x11 then 0x22:
  - Both ports read 9 on the following cycles -> 0x11, then 0x22, then 0x22 steady.
  - wb_src=3 -> no write, commit_valid = 0.
- Scoreboard:
  - sb_set addr 12 -> rd_stall[0]=1 for rd_addr0=12 next cycle.
  - sb_set 12 with sb_clr 12 in the same cycle -> still busy.
  - sb_clr 12 alone -> stall drops the following cycle.
  - sb_set 0 -> never busy.
- Reset asserted the cycle after wb_valid to register 3 with busy bits set -> register 3 reads 0, busy_mask 0, commit_valid 0 after the reset edge.
